// File: rtl/hazard_ctrl_pipe.sv
// Hazard controller for a five-stage pipeline: load-use stall, branch/jump flush, EX operand
// forwarding selects, and the EX/MEM/WB control bundles with saturating event counters.
module hazard_ctrl_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_wr_reg,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_mem_write,
  input  logic       id_branch,
  input  logic [1:0] id_pcsrc,
  input  logic [1:0] id_memtoreg,
  input  logic [3:0] id_aluop,
  input  logic       ex_branch_taken,
  output logic       stall,
  output logic       flush_if_id,
  output logic       ex_valid,
  output logic       ex_reg_write,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic [1:0] ex_memtoreg,
  output logic [3:0] ex_aluop,
  output logic       ex_branch,
  output logic [4:0] ex_wr_reg,
  output logic       mem_valid,
  output logic       mem_reg_write,
  output logic       mem_mem_read,
  output logic       mem_mem_write,
  output logic [1:0] mem_memtoreg,
  output logic [3:0] mem_aluop,
  output logic       mem_branch,
  output logic [4:0] mem_wr_reg,
  output logic       wb_valid,
  output logic       wb_reg_write,
  output logic       wb_mem_read,
  output logic       wb_mem_write,
  output logic [1:0] wb_memtoreg,
  output logic [3:0] wb_aluop,
  output logic       wb_branch,
  output logic [4:0] wb_wr_reg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memtoreg;
    logic [3:0] aluop;
    logic       branch;
    logic [4:0] wrReg;
  } bundle_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
  } srcs_t;

  bundle_t exQ, exD, memQ, wbQ;
  srcs_t   exSrcQ, exSrcD;
  logic [15:0] stallCntQ, stallCntD, flushCntQ, flushCntD;

  logic loadUse, kill, stallInt, flushInt;

  // MEM result beats WB result; register 0 is never a forwarding source.
  function automatic logic [1:0] fwdSel(input bundle_t memB, input bundle_t wbB,
                                        input logic [4:0] src, input logic uses);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && (src != 5'd0)) begin
      if (memB.valid && memB.regWrite && (memB.wrReg == src)) begin
        sel = 2'b10;
      end else if (wbB.valid && wbB.regWrite && (wbB.wrReg == src)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_comb begin
    loadUse = id_valid && exQ.valid && exQ.memRead && (exQ.wrReg != 5'd0) &&
              ((id_uses_rs && (id_rs == exQ.wrReg)) || (id_uses_rt && (id_rt == exQ.wrReg)));
    kill     = exQ.valid && exQ.branch && ex_branch_taken;
    stallInt = loadUse && !kill;
    flushInt = kill || (id_valid && (id_pcsrc != 2'b00) && !stallInt);
  end

  always_comb begin
    exD    = '0;
    exSrcD = '0;
    // A stalled or killed ID instruction leaves a bubble behind it in EX.
    if (!kill && !stallInt && id_valid) begin
      exD.valid    = 1'b1;
      exD.regWrite = id_reg_write;
      exD.memRead  = id_mem_read;
      exD.memWrite = id_mem_write;
      exD.memtoreg = id_memtoreg;
      exD.aluop    = id_aluop;
      exD.branch   = id_branch;
      exD.wrReg    = id_wr_reg;
      exSrcD.rs     = id_rs;
      exSrcD.rt     = id_rt;
      exSrcD.usesRs = id_uses_rs;
      exSrcD.usesRt = id_uses_rt;
    end
  end

  always_comb begin
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    if (stallInt && (stallCntQ != 16'hFFFF)) begin
      stallCntD = stallCntQ + 16'd1;
    end
    if (flushInt && (flushCntQ != 16'hFFFF)) begin
      flushCntD = flushCntQ + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exQ       <= '0;
      memQ      <= '0;
      wbQ       <= '0;
      exSrcQ    <= '0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      exQ       <= exD;
      memQ      <= exQ;
      wbQ       <= memQ;
      exSrcQ    <= exSrcD;
      stallCntQ <= stallCntD;
      flushCntQ <= flushCntD;
    end
  end

  assign stall       = stallInt;
  assign flush_if_id = flushInt;
  assign fwd_a       = fwdSel(memQ, wbQ, exSrcQ.rs, exSrcQ.usesRs);
  assign fwd_b       = fwdSel(memQ, wbQ, exSrcQ.rt, exSrcQ.usesRt);
  assign stall_cnt   = stallCntQ;
  assign flush_cnt   = flushCntQ;

  assign ex_valid     = exQ.valid;
  assign ex_reg_write = exQ.regWrite;
  assign ex_mem_read  = exQ.memRead;
  assign ex_mem_write = exQ.memWrite;
  assign ex_memtoreg  = exQ.memtoreg;
  assign ex_aluop     = exQ.aluop;
  assign ex_branch    = exQ.branch;
  assign ex_wr_reg    = exQ.wrReg;

  assign mem_valid     = memQ.valid;
  assign mem_reg_write = memQ.regWrite;
  assign mem_mem_read  = memQ.memRead;
  assign mem_mem_write = memQ.memWrite;
  assign mem_memtoreg  = memQ.memtoreg;
  assign mem_aluop     = memQ.aluop;
  assign mem_branch    = memQ.branch;
  assign mem_wr_reg    = memQ.wrReg;

  assign wb_valid     = wbQ.valid;
  assign wb_reg_write = wbQ.regWrite;
  assign wb_mem_read  = wbQ.memRead;
  assign wb_mem_write = wbQ.memWrite;
  assign wb_memtoreg  = wbQ.memtoreg;
  assign wb_aluop     = wbQ.aluop;
  assign wb_branch    = wbQ.branch;
  assign wb_wr_reg    = wbQ.wrReg;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: directed vector table, random stimulus against a stage-list model,
// and a long jump run that drives the flush counter into saturation.
module tb_hazard_ctrl_pipe;

  typedef struct packed {
    bit       rst;
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
    bit [4:0] wr;
    bit       rw;
    bit       mr;
    bit       mw;
    bit       br;
    bit [1:0] pcsrc;
    bit [1:0] mtr;
    bit [3:0] alu;
    bit       tkn;
  } in_t;

  typedef struct packed {
    bit        stall;
    bit        flush;
    bit [1:0]  fa;
    bit [1:0]  fb;
    bit        exV;
    bit [4:0]  exWr;
    bit        memV;
    bit [4:0]  memWr;
    bit        wbV;
    bit [4:0]  wbWr;
    bit [15:0] scnt;
    bit [15:0] fcnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  // One in-flight instruction as the model sees it.
  typedef struct packed {
    bit       v;
    bit       rw;
    bit       mr;
    bit       mw;
    bit [1:0] mtr;
    bit [3:0] alu;
    bit       br;
    bit [4:0] wr;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
  } mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic id_branch, ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic [1:0] id_pcsrc, id_memtoreg;
  logic [3:0] id_aluop;
  logic stall, flush_if_id;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_branch;
  logic wb_valid, wb_reg_write, wb_mem_read, wb_mem_write, wb_branch;
  logic [1:0] ex_memtoreg, mem_memtoreg, wb_memtoreg, fwd_a, fwd_b;
  logic [3:0] ex_aluop, mem_aluop, wb_aluop;
  logic [4:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl_pipe dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_reg(id_wr_reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_pcsrc(id_pcsrc), .id_memtoreg(id_memtoreg),
    .id_aluop(id_aluop), .ex_branch_taken(ex_branch_taken), .stall(stall),
    .flush_if_id(flush_if_id), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_memtoreg(ex_memtoreg),
    .ex_aluop(ex_aluop), .ex_branch(ex_branch), .ex_wr_reg(ex_wr_reg),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_memtoreg(mem_memtoreg), .mem_aluop(mem_aluop),
    .mem_branch(mem_branch), .mem_wr_reg(mem_wr_reg), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write),
    .wb_memtoreg(wb_memtoreg), .wb_aluop(wb_aluop), .wb_branch(wb_branch),
    .wb_wr_reg(wb_wr_reg), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  in_t cur;
  mst_t pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
  int sCnt, fCnt;
  vec_t tbl [24];

  task automatic check(input string nm, input logic [85:0] got, input logic [85:0] want);
    nCmp++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic in_t ins(int rst, int v, int rs, int rt, int urs, int urt, int wr, int rw,
                              int mr, int mw, int br, int pcsrc, int alu, int tkn);
    in_t r;
    r.rst = 1'(rst);  r.v = 1'(v);      r.rs = 5'(rs);   r.rt = 5'(rt);
    r.urs = 1'(urs);  r.urt = 1'(urt);  r.wr = 5'(wr);   r.rw = 1'(rw);
    r.mr = 1'(mr);    r.mw = 1'(mw);    r.br = 1'(br);   r.pcsrc = 2'(pcsrc);
    r.mtr = r.mr ? 2'b01 : 2'b00;       r.alu = 4'(alu); r.tkn = 1'(tkn);
    return r;
  endfunction

  function automatic exp_t ex(int s, int f, int a, int b, int ev, int ew, int mv, int mw,
                              int wv, int ww, int sc, int fc);
    exp_t e;
    e.stall = 1'(s); e.flush = 1'(f); e.fa = 2'(a);    e.fb = 2'(b);
    e.exV = 1'(ev);  e.exWr = 5'(ew); e.memV = 1'(mv); e.memWr = 5'(mw);
    e.wbV = 1'(wv);  e.wbWr = 5'(ww); e.scnt = 16'(sc); e.fcnt = 16'(fc);
    return e;
  endfunction

  task automatic drive(input in_t i);
    cur = i;
    reset = i.rst;           id_valid = i.v;          id_rs = i.rs;          id_rt = i.rt;
    id_uses_rs = i.urs;      id_uses_rt = i.urt;      id_wr_reg = i.wr;      id_reg_write = i.rw;
    id_mem_read = i.mr;      id_mem_write = i.mw;     id_branch = i.br;      id_pcsrc = i.pcsrc;
    id_memtoreg = i.mtr;     id_aluop = i.alu;        ex_branch_taken = i.tkn;
  endtask

  // Reference rules, stated directly on the list of in-flight instructions.
  function automatic bit mKill();
    return pipe[0].v && pipe[0].br && cur.tkn;
  endfunction

  function automatic bit mStall();
    bit needsLoad;
    needsLoad = (cur.urs && cur.rs == pipe[0].wr) || (cur.urt && cur.rt == pipe[0].wr);
    return cur.v && pipe[0].v && pipe[0].mr && pipe[0].wr != 0 && needsLoad && !mKill();
  endfunction

  function automatic bit mFlush();
    return mKill() || (cur.v && cur.pcsrc != 0 && !mStall());
  endfunction

  function automatic bit [1:0] mFwd(input bit [4:0] r, input bit uses);
    for (int s = 1; s <= 2; s++) begin
      if (uses && r != 0 && pipe[s].v && pipe[s].rw && pipe[s].wr == r) begin
        return (s == 1) ? 2'b10 : 2'b01;
      end
    end
    return 2'b00;
  endfunction

  function automatic bit [15:0] bund(input mst_t s);
    return {s.v, s.rw, s.mr, s.mw, s.mtr, s.alu, s.br, s.wr};
  endfunction

  function automatic logic [85:0] expVec();
    return {mStall(), mFlush(), mFwd(pipe[0].rs, pipe[0].urs), mFwd(pipe[0].rt, pipe[0].urt),
            16'(sCnt), 16'(fCnt), bund(pipe[0]), bund(pipe[1]), bund(pipe[2])};
  endfunction

  function automatic logic [85:0] actVec();
    return {stall, flush_if_id, fwd_a, fwd_b, stall_cnt, flush_cnt,
            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_memtoreg, ex_aluop,
            ex_branch, ex_wr_reg,
            mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_memtoreg, mem_aluop,
            mem_branch, mem_wr_reg,
            wb_valid, wb_reg_write, wb_mem_read, wb_mem_write, wb_memtoreg, wb_aluop,
            wb_branch, wb_wr_reg};
  endfunction

  function automatic exp_t tblAct();
    return {stall, flush_if_id, fwd_a, fwd_b, ex_valid, ex_wr_reg, mem_valid, mem_wr_reg,
            wb_valid, wb_wr_reg, stall_cnt, flush_cnt};
  endfunction

  task automatic step(input in_t i, input bit chk);
    drive(i);
    #1;
    if (chk) check($sformatf("model cyc%0d", cyc), actVec(), expVec());
  endtask

  task automatic advance();
    bit k, s, f;
    mst_t n;
    k = mKill();
    s = mStall();
    f = mFlush();
    @(posedge clk);
    if (cur.rst) begin
      foreach (pipe[j]) pipe[j] = '0;
      sCnt = 0;
      fCnt = 0;
    end else begin
      n = '0;
      if (cur.v && !k && !s) begin
        n = '{v: 1'b1, rw: cur.rw, mr: cur.mr, mw: cur.mw, mtr: cur.mtr, alu: cur.alu,
              br: cur.br, wr: cur.wr, rs: cur.rs, rt: cur.rt, urs: cur.urs, urt: cur.urt};
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = n;
      if (s && sCnt < 65535) sCnt++;
      if (f && fCnt < 65535) fCnt++;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    foreach (pipe[j]) pipe[j] = '0;
    sCnt = 0;
    fCnt = 0;

    // Load-use, forwarding priority, register 0, kill vs stall, jump, latency, reset mid-flight.
    tbl[0]  = '{ins(0,1,29,0,1,0,8,1,1,0,0,0,0,0), ex(0,0,0,0,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{ins(0,1,8,9,1,1,10,1,0,0,0,0,2,0), ex(1,0,0,0,1,8,0,0,0,0,0,0)};
    tbl[2]  = '{ins(0,1,8,9,1,1,10,1,0,0,0,0,2,0), ex(0,0,0,0,0,0,1,8,0,0,1,0)};
    tbl[3]  = '{ins(0,1,0,0,0,0,5,1,0,0,0,0,0,0),  ex(0,0,1,0,1,10,0,0,1,8,1,0)};
    tbl[4]  = '{ins(0,1,0,0,0,0,5,1,0,0,0,0,0,0),  ex(0,0,0,0,1,5,1,10,0,0,1,0)};
    tbl[5]  = '{ins(0,1,5,10,1,1,0,0,0,1,0,0,0,0), ex(0,0,0,0,1,5,1,5,1,10,1,0)};
    tbl[6]  = '{ins(0,1,5,10,1,1,0,0,0,1,0,0,0,0), ex(0,0,2,0,1,0,1,5,1,5,1,0)};
    tbl[7]  = '{ins(0,1,0,0,0,0,0,1,0,0,0,0,0,0),  ex(0,0,1,0,1,0,1,0,1,5,1,0)};
    tbl[8]  = '{ins(0,1,0,0,1,1,0,0,0,0,0,0,0,0),  ex(0,0,0,0,1,0,1,0,1,0,1,0)};
    tbl[9]  = '{ins(0,1,0,0,0,0,0,1,1,0,0,0,0,0),  ex(0,0,0,0,1,0,1,0,1,0,1,0)};
    tbl[10] = '{ins(0,1,0,0,1,0,0,0,0,0,0,0,0,0),  ex(0,0,0,0,1,0,1,0,1,0,1,0)};
    tbl[11] = '{ins(0,1,1,0,1,0,7,1,1,0,1,0,0,0),  ex(0,0,0,0,1,0,1,0,1,0,1,0)};
    tbl[12] = '{ins(0,1,7,0,1,0,3,1,0,0,0,0,0,1),  ex(0,1,0,0,1,7,1,0,1,0,1,0)};
    tbl[13] = '{ins(0,1,0,0,0,0,0,0,0,0,0,1,0,0),  ex(0,1,0,0,0,0,1,7,1,0,1,1)};
    tbl[14] = '{ins(0,1,0,0,0,0,4,1,1,0,0,0,0,0),  ex(0,0,0,0,1,0,0,0,1,7,1,2)};
    tbl[15] = '{ins(0,1,4,0,1,0,0,0,0,0,0,2,0,0),  ex(1,0,0,0,1,4,1,0,0,0,1,2)};
    tbl[16] = '{ins(0,1,4,0,1,0,0,0,0,0,0,2,0,0),  ex(0,1,0,0,0,0,1,4,1,0,2,2)};
    tbl[17] = '{ins(0,1,0,0,0,0,9,1,0,0,0,0,2,0),  ex(0,0,1,0,1,0,0,0,1,4,2,3)};
    tbl[18] = '{ins(0,0,0,0,0,0,0,0,0,0,0,0,0,0),  ex(0,0,0,0,1,9,1,0,0,0,2,3)};
    tbl[19] = '{ins(0,0,0,0,0,0,0,0,0,0,0,0,0,0),  ex(0,0,0,0,0,0,1,9,1,0,2,3)};
    tbl[20] = '{ins(0,1,0,0,0,0,9,1,0,0,0,0,2,0),  ex(0,0,0,0,0,0,0,0,1,9,2,3)};
    tbl[21] = '{ins(1,1,0,0,0,0,11,1,0,0,0,0,0,0), ex(0,0,0,0,1,9,0,0,0,0,2,3)};
    tbl[22] = '{ins(0,1,0,0,0,0,0,0,0,0,0,1,0,0),  ex(0,1,0,0,0,0,0,0,0,0,0,0)};
    tbl[23] = '{ins(0,0,0,0,0,0,0,0,0,0,0,0,0,0),  ex(0,0,0,0,1,0,0,0,0,0,0,1)};

    step(ins(1,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    advance();
    step(ins(1,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    advance();

    for (int k = 0; k < 24; k++) begin
      step(tbl[k].i, 1'b1);
      check($sformatf("vec%0d", k), 86'(tblAct()), 86'(tbl[k].e));
      advance();
    end

    for (int k = 0; k < 3000; k++) begin
      in_t r;
      r.rst   = ($urandom_range(0, 59) == 0);
      r.v     = ($urandom_range(0, 9) != 0);
      r.rs    = 5'($urandom_range(0, 7));
      r.rt    = 5'($urandom_range(0, 7));
      r.urs   = 1'($urandom_range(0, 1));
      r.urt   = 1'($urandom_range(0, 1));
      r.wr    = 5'($urandom_range(0, 7));
      r.rw    = 1'($urandom_range(0, 1));
      r.mr    = ($urandom_range(0, 2) == 0);
      r.mw    = 1'($urandom_range(0, 1));
      r.br    = ($urandom_range(0, 4) == 0);
      r.pcsrc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r.mtr   = 2'($urandom_range(0, 3));
      r.alu   = 4'($urandom_range(0, 15));
      r.tkn   = 1'($urandom_range(0, 1));
      step(r, 1'b1);
      advance();
    end

    // Back-to-back jumps flush every cycle; run past 65535 to hit the saturation point.
    step(ins(1,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b1);
    advance();
    for (int k = 0; k < 65540; k++) begin
      step(ins(0,1,0,0,0,0,0,0,0,0,0,1,0,0), k >= 65530);
      advance();
    end
    #1;
    check("flushSat", 86'(flush_cnt), 86'(16'hFFFF));
    check("stallIdle", 86'(stall_cnt), 86'(16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
